// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: request streams plus FIFO write port shared by the arbiter and its environment
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 512
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OUT_W = DATA_W + ID_W + 1;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_last_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      wr_req_o;
  logic [OUT_W-1:0]          wr_data_o;
  logic                      full_i;
  logic                      busy_o;
  logic [ID_W-1:0]           grant_id_o;
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, full_i,
    output req_ready_o, wr_req_o, wr_data_o, busy_o, grant_id_o
  );
  modport master (
    output req_valid_i, req_data_i, req_last_i, full_i,
    input  req_ready_o, wr_req_o, wr_data_o, busy_o, grant_id_o
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin packet arbiter feeding one FIFO write port, tagging words with {id, last}
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 512,
  parameter int MAX_BURST = 16
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d, rr_q, rr_d, pick, rr_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy, sel_valid, sel_last, wr;
  logic [DATA_W-1:0] sel_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end
  // descending scan so the index closest to rr_q wins
  always_comb begin
    pick = rr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req_valid_i[(int'(rr_q) + k) % NUM_REQ]) pick = ID_W'((int'(rr_q) + k) % NUM_REQ);
  end
  assign busy      = state_q == BURST;
  assign sel_valid = bus.req_valid_i[grant_q];
  assign sel_last  = bus.req_last_i[grant_q];
  assign sel_data  = bus.req_data_i[int'(grant_q)*DATA_W +: DATA_W];
  assign wr        = busy & sel_valid & ~bus.full_i;
  assign rr_nxt    = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + ID_W'(1);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (|bus.req_valid_i) begin
        state_d = BURST;
        grant_d = pick;
        cnt_d   = '0;
      end
    end else if (wr) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (sel_last || cnt_q == CNT_W'(MAX_BURST - 1)) begin
        state_d = IDLE;
        rr_d    = rr_nxt;
      end
    end
  end
  assign bus.req_ready_o = (busy & ~bus.full_i) ? (NUM_REQ'(1) << grant_q) : '0;
  assign bus.wr_req_o    = wr;
  assign bus.wr_data_o   = busy ? {grant_q, sel_last, sel_data} : '0;
  assign bus.busy_o      = busy;
  assign bus.grant_id_o  = grant_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized producers checked cycle by cycle against a round-robin packet model
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 16;
  localparam int OW = DW + 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
  fifo_wr_arbiter_if #(.NUM_REQ(3), .DATA_W(DW)) bus3 ();
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .bus(bus));
  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_W(DW), .MAX_BURST(MB)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  int checks = 0;
  int failures = 0;
  logic [DW:0] q[N][$];
  bit held[N];
  int gap_pct = 0, full_pct = 0, force_full = 0, cyc = 0;
  logic [OW-1:0] wlog[$];
  int tlog[$];
  bit m_busy;
  int m_grant, m_ptr, m_beats;
  function automatic bit pending();
    pending = m_busy;
    for (int i = 0; i < N; i++) if (q[i].size() > 0) pending = 1'b1;
  endfunction
  task automatic clear_tb();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      held[i] = 1'b0;
    end
    bus.req_valid_i = '0; bus.req_last_i = '0; bus.req_data_i = '0; bus.full_i = 1'b0;
    bus3.req_valid_i = '0; bus3.req_last_i = '0; bus3.req_data_i = '0; bus3.full_i = 1'b0;
    m_busy = 1'b0; m_ptr = 0; m_grant = 0; m_beats = 0;
    force_full = 0; gap_pct = 0; full_pct = 0; cyc = 0;
    wlog.delete(); tlog.delete();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    clear_tb();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic step();
    logic [N-1:0] v, l, exp_ready;
    logic [N*DW-1:0] d;
    logic f, exp_wr;
    logic [OW-1:0] exp_data;
    for (int i = 0; i < N; i++) begin
      if (!held[i]) held[i] = q[i].size() > 0 && $urandom_range(99) >= gap_pct;
      v[i] = held[i];
      d[i*DW +: DW] = held[i] ? q[i][0][DW-1:0] : DW'($urandom);
      l[i] = held[i] ? q[i][0][DW] : 1'($urandom);
    end
    f = (force_full > 0) ? 1'b1 : ($urandom_range(99) < full_pct);
    if (force_full > 0) force_full--;
    bus.req_valid_i = v; bus.req_data_i = d; bus.req_last_i = l; bus.full_i = f;
    #1;
    exp_ready = (m_busy && !f) ? (N'(1) << m_grant) : '0;
    exp_wr = m_busy && v[m_grant] && !f;
    exp_data = {2'(m_grant), l[m_grant], d[m_grant*DW +: DW]};
    checks += 3;
    if (bus.busy_o !== m_busy) begin failures++; $display("FAIL busy cyc=%0d got=%0b want=%0b", cyc, bus.busy_o, m_busy); end
    if (bus.req_ready_o !== exp_ready) begin failures++; $display("FAIL ready cyc=%0d got=%b want=%b", cyc, bus.req_ready_o, exp_ready); end
    if (bus.wr_req_o !== exp_wr) begin failures++; $display("FAIL wr_req cyc=%0d got=%0b want=%0b", cyc, bus.wr_req_o, exp_wr); end
    if (m_busy) begin
      checks++;
      if (bus.grant_id_o !== 2'(m_grant)) begin failures++; $display("FAIL grant cyc=%0d got=%0d want=%0d", cyc, bus.grant_id_o, m_grant); end
    end
    if (exp_wr) begin
      checks++;
      if (bus.wr_data_o !== exp_data) begin failures++; $display("FAIL wr_data cyc=%0d got=%h want=%h", cyc, bus.wr_data_o, exp_data); end
    end
    if (bus.wr_req_o) begin wlog.push_back(bus.wr_data_o); tlog.push_back(cyc); end
    if (!m_busy) begin
      for (int k = 0; k < N && !m_busy; k++)
        if (v[(m_ptr + k) % N]) begin m_grant = (m_ptr + k) % N; m_busy = 1'b1; m_beats = 0; end
    end else if (exp_wr) begin
      m_beats++;
      held[m_grant] = 1'b0;
      void'(q[m_grant].pop_front());
      if (l[m_grant] || m_beats == MB) begin m_busy = 1'b0; m_ptr = (m_grant + 1) % N; end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic drain(input int limit);
    int n = 0;
    while (pending() && n < limit) begin step(); n++; end
    checks++;
    if (pending()) begin failures++; $display("FAIL drain_timeout got=%0d cycles want<%0d", n, limit); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid_i = '1; bus.req_last_i = '1; bus.req_data_i = '1; bus.full_i = 1'b0;
    bus3.req_valid_i = '1; bus3.req_last_i = '1; bus3.req_data_i = '1; bus3.full_i = 1'b0;
    @(posedge clk);
    #1;
    checks += 6;
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", bus.busy_o); end
    if (bus.wr_req_o !== 1'b0) begin failures++; $display("FAIL rst_wr_req got=%b want=0", bus.wr_req_o); end
    if (bus.req_ready_o !== '0) begin failures++; $display("FAIL rst_ready got=%b want=0", bus.req_ready_o); end
    if (bus.grant_id_o !== '0) begin failures++; $display("FAIL rst_grant got=%0d want=0", bus.grant_id_o); end
    if (bus.wr_data_o !== '0) begin failures++; $display("FAIL rst_wr_data got=%h want=0", bus.wr_data_o); end
    if (bus3.wr_req_o !== 1'b0) begin failures++; $display("FAIL rst_wr_req3 got=%b want=0", bus3.wr_req_o); end
    do_reset();
  endtask
  task automatic test_single_packet();
    do_reset();
    q[2].push_back({1'b0, 16'hA}); q[2].push_back({1'b0, 16'hB}); q[2].push_back({1'b1, 16'hC});
    drain(20);
    checks++;
    if (wlog.size() != 3) begin failures++; $display("FAIL single_count got=%0d want=3", wlog.size()); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (wlog[k][OW-1 -: 2] !== 2'd2) begin failures++; $display("FAIL single_id%0d got=%0d want=2", k, wlog[k][OW-1 -: 2]); end
        if (wlog[k][DW] !== (k == 2)) begin failures++; $display("FAIL single_last%0d got=%0b want=%0b", k, wlog[k][DW], k == 2); end
        if (tlog[k] != k + 1) begin failures++; $display("FAIL single_cycle%0d got=%0d want=%0d", k, tlog[k], k + 1); end
      end
    end
    q[0].push_back({1'b1, 16'h1}); q[3].push_back({1'b1, 16'h3});
    drain(20);
    checks++;
    if (wlog.size() != 5 || wlog[3][OW-1 -: 2] !== 2'd3 || wlog[4][OW-1 -: 2] !== 2'd0) begin
      failures++; $display("FAIL single_rr_ptr got_count=%0d want ids 3 then 0", wlog.size());
    end
  endtask
  task automatic test_all_one_beat();
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) q[i].push_back({1'b1, DW'(i)});
    q[0].push_back({1'b1, 16'h40});
    drain(40);
    checks++;
    if (wlog.size() != 5) begin failures++; $display("FAIL all_count got=%0d want=5", wlog.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (wlog[k][OW-1 -: 2] !== 2'(exp_ids[k])) begin failures++; $display("FAIL all_id%0d got=%0d want=%0d", k, wlog[k][OW-1 -: 2], exp_ids[k]); end
        if (k > 0) begin
          checks++;
          if (tlog[k] - tlog[k-1] != 2) begin failures++; $display("FAIL all_gap%0d got=%0d want=2", k, tlog[k] - tlog[k-1]); end
        end
      end
    end
  endtask
  task automatic test_forced_rotation();
    int exp_ids[$];
    int j = 0;
    do_reset();
    for (int k = 0; k < 40; k++) q[1].push_back({k == 39, DW'(16'h100 + k)});
    for (int k = 0; k < 3; k++) q[3].push_back({1'b1, DW'(16'h300 + k)});
    repeat (16) exp_ids.push_back(1); exp_ids.push_back(3);
    repeat (16) exp_ids.push_back(1); exp_ids.push_back(3);
    repeat (8) exp_ids.push_back(1); exp_ids.push_back(3);
    drain(200);
    checks++;
    if (wlog.size() != exp_ids.size()) begin failures++; $display("FAIL rot_count got=%0d want=%0d", wlog.size(), exp_ids.size()); end
    else begin
      for (int k = 0; k < exp_ids.size(); k++) begin
        checks++;
        if (wlog[k][OW-1 -: 2] !== 2'(exp_ids[k])) begin failures++; $display("FAIL rot_id%0d got=%0d want=%0d", k, wlog[k][OW-1 -: 2], exp_ids[k]); end
        if (exp_ids[k] == 1) begin
          checks++;
          if (wlog[k][DW:0] !== {j == 39, DW'(16'h100 + j)}) begin failures++; $display("FAIL rot_s1_beat%0d got=%h want=%h", j, wlog[k][DW:0], {j == 39, DW'(16'h100 + j)}); end
          j++;
        end
      end
    end
  endtask
  task automatic test_full_stall();
    int n = 0;
    do_reset();
    for (int k = 0; k < 4; k++) q[0].push_back({k == 3, DW'(16'h10 + k)});
    while (wlog.size() < 1 && n < 10) begin step(); n++; end
    force_full = 5;
    repeat (5) step();
    checks++;
    if (wlog.size() != 1) begin failures++; $display("FAIL stall_no_write got=%0d want=1", wlog.size()); end
    step();
    checks++;
    if (wlog.size() != 2 || wlog[1][DW-1:0] !== 16'h11 || tlog[1] - tlog[0] != 6) begin
      failures++; $display("FAIL stall_resume got_count=%0d want beat2=0011 six cycles after beat1", wlog.size());
    end
    drain(20);
  endtask
  task automatic test_reset_mid_burst();
    int n = 0;
    do_reset();
    q[0].push_back({1'b1, 16'h1F});
    drain(10);
    for (int k = 0; k < 8; k++) q[2].push_back({k == 7, DW'(16'h20 + k)});
    while (wlog.size() < 4 && n < 20) begin step(); n++; end
    rst = 1'b1;
    #1;
    checks += 4;
    if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b want=0", bus.busy_o); end
    if (bus.wr_req_o !== 1'b0) begin failures++; $display("FAIL mid_rst_wr_req got=%b want=0", bus.wr_req_o); end
    if (bus.req_ready_o !== '0) begin failures++; $display("FAIL mid_rst_ready got=%b want=0", bus.req_ready_o); end
    if (bus.grant_id_o !== '0) begin failures++; $display("FAIL mid_rst_grant got=%0d want=0", bus.grant_id_o); end
    clear_tb();
    @(posedge clk);
    #1 rst = 1'b0;
    q[0].push_back({1'b1, 16'h50}); q[3].push_back({1'b1, 16'h53});
    drain(20);
    checks++;
    if (wlog.size() != 2 || wlog[0][OW-1 -: 2] !== 2'd0 || wlog[1][OW-1 -: 2] !== 2'd3) begin
      failures++; $display("FAIL mid_rst_restart got_count=%0d want ids 0 then 3", wlog.size());
    end
  endtask
  task automatic test_random();
    do_reset();
    gap_pct = 30;
    full_pct = 20;
    for (int i = 0; i < N; i++)
      repeat ($urandom_range(3, 6)) begin
        int len = $urandom_range(1, 40);
        for (int k = 0; k < len; k++) q[i].push_back({k == len - 1, DW'($urandom)});
      end
    drain(20000);
    gap_pct = 0;
    full_pct = 0;
  endtask
  task automatic test_nonpow2();
    int ids[$];
    int n = 0;
    do_reset();
    bus3.req_valid_i = '1; bus3.req_last_i = '1; bus3.req_data_i = {16'd2, 16'd1, 16'd0};
    while (ids.size() < 6 && n < 40) begin
      #1;
      if (bus3.wr_req_o) begin
        ids.push_back(int'(bus3.wr_data_o[OW-1 -: 2]));
        checks++;
        if (bus3.wr_data_o[DW-1:0] !== DW'(bus3.wr_data_o[OW-1 -: 2])) begin failures++; $display("FAIL np2_data got=%h want=id", bus3.wr_data_o); end
      end
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (ids.size() != 6) begin failures++; $display("FAIL np2_count got=%0d want=6", ids.size()); end
    else for (int k = 0; k < 6; k++) begin
      checks++;
      if (ids[k] != k % 3) begin failures++; $display("FAIL np2_id%0d got=%0d want=%0d", k, ids[k], k % 3); end
    end
    bus3.req_valid_i = '0;
  endtask
  initial begin
    test_reset();
    test_single_packet();
    test_all_one_beat();
    test_forced_rotation();
    test_full_stall();
    test_reset_mid_burst();
    test_random();
    test_nonpow2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
